// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one byte per frame and sends it LSB first.
// Optional even-parity bit (8E1) is enabled by defining FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       buf_empty,
  input  logic [7:0] buf_out,
  output logic       rd_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY = 3'd5,
`endif
    STOP   = 3'd6
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [2:0]      idx_r, idx_s;
  logic [7:0]      shift_r, shift_s;
  logic            tx_r, tx_s;
  logic            bit_end_s;
`ifdef FIFO_UART_TX_PARITY_EN
  logic            parity_r, parity_s;
`endif

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  assign bit_end_s  = (cnt_r == LAST);
  assign rd_en      = (state_r == READ);
  assign busy       = (state_r != IDLE);
  assign frame_done = (state_r == STOP) && bit_end_s;
  assign tx         = tx_r;

  // State, baud counter, bit index, shift register and registered line output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      idx_r    <= 3'd0;
      shift_r  <= 8'h00;
      tx_r     <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      idx_r    <= idx_s;
      shift_r  <= shift_s;
      tx_r     <= tx_s;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_r <= parity_s;
`endif
    end
  end

  // Next-state logic; the counter restarts from zero on every bit boundary or state entry
  always_comb begin
    state_s  = state_r;
    cnt_s    = '0;
    idx_s    = idx_r;
    shift_s  = shift_r;
    tx_s     = 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_s = parity_r;
`endif
    case (state_r)
      IDLE: begin
        if (enable && !buf_empty) state_s = READ;
        else                      state_s = IDLE;
      end
      READ: state_s = LOAD;
      LOAD: begin
        shift_s  = buf_out;
        idx_s    = 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_s = even_parity(buf_out);
`endif
        state_s  = START;
      end
      START: begin
        if (bit_end_s) state_s = DATA;
        else           cnt_s   = cnt_r + CW'(1);
      end
      DATA: begin
        if (bit_end_s) begin
          shift_s = {1'b0, shift_r[7:1]};
          if (idx_r == 3'd7) begin
            idx_s = 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
          end else begin
            idx_s = idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end_s) state_s = STOP;
        else           cnt_s   = cnt_r + CW'(1);
      end
`endif
      STOP: begin
        if (bit_end_s) begin
          if (enable && !buf_empty) state_s = READ;
          else                      state_s = IDLE;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: state_s = IDLE;
    endcase

    // Line level follows the state being entered so tx changes on the bit edge itself
    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  tx_s = parity_s;
`endif
      default: tx_s = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small FIFO model; frames are hand-computed tables.
module tb_fifo_uart_tx;
  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       buf_empty;
  logic [7:0] buf_out = 8'h00;
  logic       rd_en, tx, busy, frame_done;

  logic [7:0] mem [16];
  logic [3:0] wr_ptr = 4'd0;
  logic [3:0] rd_ptr = 4'd0;
  int underflow = 0;
  int n_tests = 0;
  int n_fail = 0;

  // frame: tx order left to right (start, d0..d7, stop); par: expected even parity
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par;
  } vec_t;
  vec_t vecs[8];

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .buf_empty(buf_empty),
    .buf_out(buf_out), .rd_en(rd_en), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  assign buf_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rd_en) begin
      if (buf_empty) underflow <= underflow + 1;
      buf_out <= mem[rd_ptr];
      rd_ptr  <= rd_ptr + 4'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  task automatic wait_rd(input int budget);
    int k = 0;
    while (rd_en !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("rd_en_arrives", rd_en, 1);
  endtask

  // Starts at the negedge where rd_en is high; ends at the negedge of the last stop cycle
  task automatic check_frame(input vec_t v, input int drop_at);
    logic exp_tx;
    int k;
    for (int c = 0; c < 2 + CPB * NB; c++) begin
      if (c > 0) @(negedge clk);
      if (c == drop_at) enable = 1'b0;
      k = (c - 2) / CPB;
      if (c < 2)                  exp_tx = 1'b1;
      else if (k < 9)             exp_tx = v.frame[9 - k];
      else if (NB == 11 && k == 9) exp_tx = v.par;
      else                        exp_tx = 1'b1;
      chk($sformatf("tx[%02h c%0d]", v.data, c), tx, exp_tx);
      chk($sformatf("rd_en[%02h c%0d]", v.data, c), rd_en, c == 0);
      chk($sformatf("busy[%02h c%0d]", v.data, c), busy, 1);
      chk($sformatf("frame_done[%02h c%0d]", v.data, c), frame_done, c == 1 + CPB * NB);
    end
  endtask

  task automatic chk_idle(input string name);
    @(negedge clk);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_tx"}, tx, 1);
    chk({name, "_rd_en"}, rd_en, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 10'b0101001011, 1'b0};
    vecs[1] = '{8'h07, 10'b0111000001, 1'b1};
    vecs[2] = '{8'h03, 10'b0110000001, 1'b0};
    vecs[3] = '{8'h00, 10'b0000000001, 1'b0};
    vecs[4] = '{8'h01, 10'b0100000001, 1'b1};
    vecs[5] = '{8'h80, 10'b0000000011, 1'b1};
    vecs[6] = '{8'hFF, 10'b0111111111, 1'b0};
    vecs[7] = '{8'h3C, 10'b0001111001, 1'b0};

    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_done", frame_done, 0);
    rst_n = 1'b1;

    // empty FIFO with enable high: nothing may happen
    enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("empty_rd_en", rd_en, 0);
      chk("empty_tx", tx, 1);
      chk("empty_busy", busy, 0);
    end

    // single-byte frames from the table
    for (int i = 0; i < 4; i++) begin
      push(vecs[i].data);
      @(negedge clk);
      wait_rd(10);
      check_frame(vecs[i], -1);
      chk_idle("single_end");
    end

    // three queued bytes back to back: 2 idle-level cycles between frames
    enable = 1'b0;
    push(vecs[4].data);
    push(vecs[5].data);
    push(vecs[6].data);
    @(negedge clk);
    chk("b2b_gated_rd_en", rd_en, 0);
    enable = 1'b1;
    @(negedge clk);
    wait_rd(10);
    for (int i = 4; i < 7; i++) begin
      if (i > 4) @(negedge clk);
      check_frame(vecs[i], -1);
    end
    chk_idle("b2b_end");

    // enable dropped during data bit 3: frame completes, second byte stays queued
    enable = 1'b0;
    push(vecs[7].data);
    push(8'h55);
    enable = 1'b1;
    @(negedge clk);
    wait_rd(10);
    check_frame(vecs[7], 2 + CPB * 4 + 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("drop_rd_en", rd_en, 0);
      chk("drop_busy", busy, 0);
    end
    chk("drop_still_queued", buf_empty, 0);

    // reset in the middle of data bit 1 of 0x55 (a 0 on the line)
    enable = 1'b1;
    wait_rd(10);
    repeat (10) @(negedge clk);
    chk("pre_reset_tx", tx, 0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_tx", tx, 1);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_rd_en", rd_en, 0);
    push(vecs[0].data);
    repeat (2) @(negedge clk);
    chk("held_reset_tx", tx, 1);
    rst_n = 1'b1;
    @(negedge clk);
    wait_rd(10);
    check_frame(vecs[0], -1);
    chk_idle("post_reset_end");

    chk("no_underflow", underflow, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
